// File: rtl/draw_sprite_engine.sv
// Draw-sprite responder: walks a 16x16 sprite from the image ROM and writes its
// non-transparent, on-screen pixels into the linear 320x240 frame buffer.
module draw_sprite_engine #(
   parameter int               SPR_DIM = 16,
   parameter int               SCR_W   = 320,
   parameter int               SCR_H   = 240,
   parameter int               PIX_W   = 8,
   parameter logic [PIX_W-1:0] TRANSP  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       image,
   input  logic [16:0]      coordinates,
   output logic             rdy,
   output logic [15:0]      rom_addr,
   input  logic [PIX_W-1:0] rom_data,
   output logic             fb_we,
   output logic [16:0]      fb_addr,
   output logic [PIX_W-1:0] fb_wdata
);

   localparam int          CW      = $clog2(SPR_DIM);
   localparam logic [16:0] SCR_W17 = 17'(SCR_W);

   typedef enum logic [1:0] {IDLE, CALC_X, DRAW, FLUSH} state_t;

   state_t            state, state_nxt;
   logic [7:0]        img;
   logic [CW-1:0]     row, col;
   logic [16:0]       base, x_rem, row_base;
   logic [7:0]        y_cnt;
   logic [9:0]        x_sum;
   logic [8:0]        y_sum;

   logic              vld_p1, vis_p1;
   logic [16:0]       addr_p1;
   logic [16:0]       fb_addr_q;
   logic [PIX_W-1:0]  fb_wdata_q;

   assign rdy      = (state == IDLE);
   assign rom_addr = {img, row, col};
   assign x_sum    = {1'b0, x_rem[8:0]} + 10'(col);
   assign y_sum    = {1'b0, y_cnt} + 9'(row);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // y_cnt is tested before subtracting so large coordinates can never wrap it
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (start) state_nxt = CALC_X;
         CALC_X: begin
            if (y_cnt >= 8'(SCR_H))      state_nxt = IDLE;
            else if (x_rem < SCR_W17)    state_nxt = DRAW;
         end
         DRAW:   if (row == '1 && col == '1) state_nxt = FLUSH;
         FLUSH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         img <= '0;
         row <= '0;
         col <= '0;
      end else begin
         case (state)
            IDLE: if (start) img <= image;
            CALC_X: begin
               row <= '0;
               col <= '0;
            end
            DRAW: begin
               col <= col + 1'b1;
               if (col == '1) row <= row + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      case (state)
         IDLE: if (start) begin
            base  <= coordinates;
            x_rem <= coordinates;
            y_cnt <= '0;
         end
         CALC_X: begin
            if (x_rem >= SCR_W17 && y_cnt < 8'(SCR_H)) begin
               x_rem <= x_rem - SCR_W17;
               y_cnt <= y_cnt + 1'b1;
            end
            row_base <= base;
         end
         DRAW: if (col == '1) row_base <= row_base + SCR_W17;
         default: ;
      endcase
   end

   // ---- write stage: aligned with rom_data for the address issued last cycle ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_p1 <= 1'b0;
      else        vld_p1 <= (state == DRAW);
   end

   always_ff @(posedge clk) begin
      vis_p1  <= (x_sum < 10'(SCR_W)) && (y_sum < 9'(SCR_H));
      addr_p1 <= row_base + 17'(col);
   end

   assign fb_we = vld_p1 && vis_p1 && (rom_data != TRANSP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fb_addr_q  <= '0;
         fb_wdata_q <= '0;
      end else if (fb_we) begin
         fb_addr_q  <= addr_p1;
         fb_wdata_q <= rom_data;
      end
   end

   assign fb_addr  = fb_we ? addr_p1  : fb_addr_q;
   assign fb_wdata = fb_we ? rom_data : fb_wdata_q;

endmodule

// File: tb/tb_draw_sprite_engine.sv
// Directed bench for draw_sprite_engine: ROM model, write monitor and latency checks.
module tb_draw_sprite_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  image = '0;
   logic [16:0] coordinates = '0;
   logic        rdy;
   logic [15:0] rom_addr;
   logic [7:0]  rom_data = '0;
   logic        fb_we;
   logic [16:0] fb_addr;
   logic [7:0]  fb_wdata;

   int checks = 0;
   int errors = 0;
   int cyc;
   int mode;
   logic [7:0] exp_img;
   int wr_cnt, bad_cnt;
   logic [16:0] first_addr, last_addr;

   draw_sprite_engine dut (
      .clk(clk), .rst_n(rst_n), .start(start), .image(image),
      .coordinates(coordinates), .rdy(rdy), .rom_addr(rom_addr),
      .rom_data(rom_data), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: mode 0 solid 0x55, mode 1 transparent on even columns, mode 2 = image index
   always @(posedge clk) begin
      case (mode)
         0:       rom_data <= 8'h55;
         1:       rom_data <= rom_addr[0] ? {4'hA, rom_addr[3:0]} : 8'h00;
         default: rom_data <= rom_addr[15:8];
      endcase
   end

   always @(negedge clk) begin
      if (fb_we) begin
         if (wr_cnt == 0) first_addr = fb_addr;
         last_addr = fb_addr;
         wr_cnt++;
         case (mode)
            0: if (fb_wdata != 8'h55) bad_cnt++;
            1: if ((fb_addr % 320) % 2 != 1 || fb_wdata != {4'hA, 4'(fb_addr % 320)}) bad_cnt++;
            default: if (fb_wdata != exp_img) bad_cnt++;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic clr_mon(input logic [7:0] img);
      wr_cnt = 0; bad_cnt = 0; first_addr = '0; last_addr = '0; exp_img = img;
   endtask

   task automatic launch(input logic [7:0] img, input logic [16:0] coord, input bit hold);
      @(negedge clk);
      start = 1'b1; image = img; coordinates = coord;
      clr_mon(img);
      @(posedge clk); #1;
      cyc = 0;
      chk("accept_rdy_low", rdy, 0);
      if (!hold) start = 1'b0;
   endtask

   task automatic wait_rdy(input string tag, input int exp_lat);
      while (!rdy && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk(tag, cyc, exp_lat);
   endtask

   task automatic chk_draw(input string tag, input int n, input int fa, input int la);
      chk({tag, "_writes"}, wr_cnt, n);
      if (n > 0) begin
         chk({tag, "_first"}, first_addr, fa);
         chk({tag, "_last"}, last_addr, la);
      end
      chk({tag, "_data"}, bad_cnt, 0);
   endtask

   initial begin
      mode = 0;
      clr_mon(8'h00);
      #12;
      chk("rst_rdy", rdy, 1);
      chk("rst_fb_we", fb_we, 0);
      chk("rst_fb_addr", fb_addr, 0);
      chk("rst_fb_wdata", fb_wdata, 0);
      chk("rst_rom_addr", rom_addr, 0);
      @(negedge clk); rst_n = 1'b1;

      // T1: reset mid-draw
      launch(8'd2, 17'd0, 0);
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("t1_pre_we", fb_we, 1);
      rst_n = 1'b0;
      #1;
      chk("t1_we_async", fb_we, 0);
      chk("t1_rdy", rdy, 1);
      chk("t1_fb_addr", fb_addr, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(posedge clk);
      chk("t1_idle_after", rdy, 1);

      // T2: coord 0, image 3, solid ROM
      launch(8'd3, 17'd0, 0);
      @(posedge clk); #1; cyc++;
      chk("t2_rom_addr", rom_addr, 16'h0300);
      wait_rdy("t2_latency", 258);
      chk_draw("t2", 256, 0, 4815);

      // T3: transparent even columns
      mode = 1;
      launch(8'd1, 17'd0, 0);
      wait_rdy("t3_latency", 258);
      chk_draw("t3", 128, 1, 4815);

      // T4: right-edge clip
      mode = 0;
      launch(8'd4, 17'd3510, 0);
      wait_rdy("t4_latency", 268);
      chk_draw("t4", 160, 3510, 8319);

      // T5: bottom-edge clip, then fully off-screen
      launch(8'd4, 17'd73600, 0);
      wait_rdy("t5a_latency", 488);
      chk_draw("t5a", 160, 73600, 76495);
      launch(8'd4, 17'd76800, 0);
      wait_rdy("t5b_latency", 241);
      chk_draw("t5b", 0, 0, 0);

      // T6: start held, inputs changed while busy
      mode = 2;
      launch(8'd5, 17'd0, 1);
      image = 8'd9; coordinates = 17'd1600;
      wait_rdy("t6a_latency", 258);
      chk_draw("t6a", 256, 0, 4815);
      clr_mon(8'd9);
      @(posedge clk); #1;
      cyc = 0;
      chk("t6b_accept", rdy, 0);
      start = 1'b0;
      wait_rdy("t6b_latency", 263);
      chk_draw("t6b", 256, 1600, 6415);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
